prog_mem: RTL and testbench

//  Parametrised, writable program memory with a registered fetch port; the

---
 rtl/prog_mem.sv | 173 +++++++++++++++++
 tb/tb_prog_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem
// Purpose  : Writable program memory with a registered fetch port. After
//            reset the array is filled with DEFAULT_WORD, one word per cycle,
//            then registered fetches are served to the CPU front end. A
//            sequential load port lets the boot path overwrite the program
//            from address 0 upward.
// Ports    : CLK, RST           clock / synchronous active-high reset
//            FETCH_REQ/ADDR     fetch request and address (1-cycle latency)
//            FETCH_STALL        hold COMMAND/CMD_VALID, ignore FETCH_REQ
//            COMMAND/CMD_VALID  registered fetched word and its valid flag
//            LOAD_EN            level, load session active
//            LOAD_VALID/DATA    load word strobe and data
//            LOAD_DONE          one-cycle pulse when a load session ends
//            LOAD_OVF           sticky, a load word was dropped (memory full)
//            BUSY               high while clearing or loading
// Revision : 1.0  initial release
// ============================================================================
module prog_mem #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH        = 256,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = 16'h4601
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FETCH_REQ,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  input  logic              FETCH_STALL,
  output logic [DATA_W-1:0] COMMAND,
  output logic              CMD_VALID,
  input  logic              LOAD_EN,
  input  logic              LOAD_VALID,
  input  logic [DATA_W-1:0] LOAD_DATA,
  output logic              LOAD_DONE,
  output logic              LOAD_OVF,
  output logic              BUSY
);

  // Array index width (at least one bit so DEPTH=1 still elaborates).
  localparam int c_MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The pointer must be able to hold the value DEPTH itself: a full load
  // parks it there and further words are dropped instead of wrapping.
  localparam int c_PTR_W  = $clog2(DEPTH + 1);

  // Fetch range check runs on the full address width plus one bit, so a
  // DEPTH equal to 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]    c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_DEPTH = c_PTR_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_PTR_W-1:0]  r_ptr;        // shared fill / load write pointer
  logic                r_cmd_valid;
  logic                r_load_done;
  logic                r_load_ovf;
  logic                r_use_dflt;   // COMMAND shows DEFAULT_WORD, not RAM data
  logic [DATA_W-1:0]   r_rd_data;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_in_range;
  logic                w_run_fetch;
  logic                w_re;
  logic                w_load_wr;
  logic                w_we;
  logic [c_MEM_AW-1:0] w_waddr;
  logic [c_MEM_AW-1:0] w_raddr;
  logic [DATA_W-1:0]   w_wdata;

  // --------------------------------------------------------------------------
  // Memory port control. Writes only occur in CLEAR/LOAD and reads only in
  // RUN, so the single port is never asked to do both in one cycle.
  // --------------------------------------------------------------------------
  assign w_in_range  = ({1'b0, FETCH_ADDR} < c_DEPTH_EXT);
  assign w_run_fetch = (r_state == S_RUN) && !LOAD_EN && !FETCH_STALL && FETCH_REQ;
  assign w_re        = !RST && w_run_fetch && w_in_range;
  assign w_load_wr   = (r_state == S_LOAD) && LOAD_EN && LOAD_VALID &&
                       (r_ptr < c_PTR_DEPTH);
  assign w_we        = !RST && ((r_state == S_CLEAR) || w_load_wr);
  assign w_waddr     = r_ptr[c_MEM_AW-1:0];
  assign w_raddr     = FETCH_ADDR[c_MEM_AW-1:0];
  assign w_wdata     = (r_state == S_CLEAR) ? DEFAULT_WORD : LOAD_DATA;

  // Plain synchronous single-port RAM with a read-enabled output register,
  // kept free of reset so it maps onto block RAM. The read register only
  // updates on an accepted in-range fetch, which gives the hold behaviour.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    if (w_re) begin
      r_rd_data <= r_mem[w_raddr];
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: CLEAR -> RUN <-> LOAD
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_CLEAR;
      r_ptr       <= '0;
      r_cmd_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_load_ovf  <= 1'b0;
      r_use_dflt  <= 1'b1;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          // One default word per cycle; the last write is at DEPTH-1.
          if (r_ptr == c_PTR_LAST) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end

        S_RUN: begin
          if (LOAD_EN) begin
            // Load entry wins over any fetch presented in the same cycle.
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_load_ovf  <= 1'b0;
            r_cmd_valid <= 1'b0;
          end else if (FETCH_STALL) begin
            r_cmd_valid <= r_cmd_valid;
          end else if (FETCH_REQ) begin
            r_cmd_valid <= 1'b1;
            r_use_dflt  <= !w_in_range;
          end else begin
            r_cmd_valid <= 1'b0;
          end
        end

        S_LOAD: begin
          if (!LOAD_EN) begin
            r_state     <= S_RUN;
            r_load_done <= 1'b1;
          end else if (LOAD_VALID) begin
            if (r_ptr < c_PTR_DEPTH) begin
              r_ptr <= r_ptr + 1'b1;
            end else begin
              r_load_ovf <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign COMMAND   = r_use_dflt ? DEFAULT_WORD : r_rd_data;
  assign CMD_VALID = r_cmd_valid;
  assign LOAD_DONE = r_load_done;
  assign LOAD_OVF  = r_load_ovf;
  assign BUSY      = (r_state != S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem
// Purpose  : Self-checking bench for prog_mem. Two instances (DEPTH=256 and
//            DEPTH=4) share one stimulus stream; each is compared every cycle
//            against a behavioural model, with literal checks on the
//            directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_mem;

  localparam logic [15:0] DFLT = 16'h4601;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_req, fetch_stall, load_en, load_valid;
  logic [15:0] fetch_addr, load_data;

  logic [15:0] cmd_a, cmd_b;
  logic        valid_a, valid_b, done_a, done_b, ovf_a, ovf_b, busy_a, busy_b;

  prog_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .DEFAULT_WORD(DFLT)) dut (
    .CLK(clk), .RST(rst), .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
    .FETCH_STALL(fetch_stall), .COMMAND(cmd_a), .CMD_VALID(valid_a),
    .LOAD_EN(load_en), .LOAD_VALID(load_valid), .LOAD_DATA(load_data),
    .LOAD_DONE(done_a), .LOAD_OVF(ovf_a), .BUSY(busy_a)
  );

  prog_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .DEFAULT_WORD(DFLT)) dut4 (
    .CLK(clk), .RST(rst), .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
    .FETCH_STALL(fetch_stall), .COMMAND(cmd_b), .CMD_VALID(valid_b),
    .LOAD_EN(load_en), .LOAD_VALID(load_valid), .LOAD_DATA(load_data),
    .LOAD_DONE(done_b), .LOAD_OVF(ovf_b), .BUSY(busy_b)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: memory contents as an array, the clear phase as a
  // countdown of remaining busy cycles, a load session as a flag + index.
  // --------------------------------------------------------------------------
  logic [15:0] m_mem [2][256];
  int          m_clear [2];
  bit          m_load  [2];
  int          m_idx   [2];
  logic [15:0] e_cmd   [2];
  bit          e_valid [2], e_done [2], e_ovf [2];
  bit          m_started = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  task automatic model_step(input int k);
    int d;
    d = depth_of(k);
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[k][i] = DFLT;
      m_clear[k] = d;
      m_load[k]  = 0;
      m_idx[k]   = 0;
      e_cmd[k]   = DFLT;
      e_valid[k] = 0;
      e_done[k]  = 0;
      e_ovf[k]   = 0;
    end else begin
      e_done[k] = 0;
      if (m_clear[k] > 0) begin
        m_clear[k]--;
      end else if (m_load[k]) begin
        if (!load_en) begin
          m_load[k] = 0;
          e_done[k] = 1;
        end else if (load_valid) begin
          if (m_idx[k] < d) begin
            m_mem[k][m_idx[k]] = load_data;
            m_idx[k]++;
          end else begin
            e_ovf[k] = 1;
          end
        end
      end else if (load_en) begin
        m_load[k]  = 1;
        m_idx[k]   = 0;
        e_ovf[k]   = 0;
        e_valid[k] = 0;
      end else if (!fetch_stall) begin
        if (fetch_req) begin
          e_cmd[k]   = (int'(fetch_addr) < d) ? m_mem[k][fetch_addr[7:0]] : DFLT;
          e_valid[k] = 1;
        end else begin
          e_valid[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_started = 1;
    if (m_started) begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("cmd[256]",   cmd_a,   e_cmd[0]);
      chk("valid[256]", valid_a, e_valid[0]);
      chk("done[256]",  done_a,  e_done[0]);
      chk("ovf[256]",   ovf_a,   e_ovf[0]);
      chk("busy[256]",  busy_a,  (m_clear[0] > 0) || m_load[0]);
      chk("cmd[4]",     cmd_b,   e_cmd[1]);
      chk("valid[4]",   valid_b, e_valid[1]);
      chk("done[4]",    done_b,  e_done[1]);
      chk("ovf[4]",     ovf_b,   e_ovf[1]);
      chk("busy[4]",    busy_b,  (m_clear[1] > 0) || m_load[1]);
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  logic [15:0] lq [$];

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (busy_a && n < 400) begin
      @(negedge clk);
      chk({nm, "_no_done"}, done_a, 1'b0);
      n++;
    end
    chk({nm, "_busy_cycles"}, n, 256);
  endtask

  task automatic do_load();
    @(negedge clk); load_en = 1; load_valid = 0;
    foreach (lq[i]) begin
      @(negedge clk); load_valid = 1; load_data = lq[i];
    end
    @(negedge clk); load_valid = 0; load_en = 0;
    @(negedge clk); chk("load_done_pulse", done_a, 1'b1);
    @(negedge clk); chk("load_done_end", done_a, 1'b0);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk); fetch_req = 1; fetch_addr = a;
    @(negedge clk); fetch_req = 0;
    chk(nm, cmd_a, exp);
    chk({nm, "_valid"}, valid_a, 1'b1);
  endtask

  bit tb_in_load;
  int r;

  initial begin
    rst = 1; fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
    load_en = 0; load_valid = 0; load_data = 0;

    // 1: reset state, clear length, default fetch
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_cmd", cmd_a, DFLT);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_ovf", ovf_a, 1'b0);
    rst = 0;
    wait_clear("clear");
    fetch(16'h0005, DFLT, "fetch5_default");

    // 2: short load, read back
    lq = '{16'h5C00, 16'h80C9, 16'h6240};
    do_load();
    fetch(16'h0001, 16'h80C9, "fetch1_loaded");
    chk("model_pin_80c9", e_cmd[0], 16'h80C9);
    fetch(16'h0003, DFLT, "fetch3_unloaded");

    // 3: back-to-back fetches
    @(negedge clk); fetch_req = 1; fetch_addr = 0;
    @(negedge clk); chk("b2b0", cmd_a, 16'h5C00); chk("b2b0_v", valid_a, 1'b1); fetch_addr = 1;
    @(negedge clk); chk("b2b1", cmd_a, 16'h80C9); chk("b2b1_v", valid_a, 1'b1); fetch_addr = 2;
    @(negedge clk); chk("b2b2", cmd_a, 16'h6240); chk("b2b2_v", valid_a, 1'b1); fetch_req = 0;

    // 4: out-of-range fetch then stall hold
    fetch(16'h012C, DFLT, "fetch300_oor");
    fetch_stall = 1; fetch_req = 1; fetch_addr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cmd", cmd_a, DFLT);
      chk("stall_valid", valid_a, 1'b1);
    end
    fetch_stall = 0; fetch_req = 0;

    // 5: overflow on the DEPTH=4 instance
    lq = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D, 16'hE00E};
    do_load();
    chk("ovf_small", ovf_b, 1'b1);
    chk("ovf_big", ovf_a, 1'b0);
    fetch(16'h0000, 16'hA00A, "fetch0_big");
    chk("fetch0_small", cmd_b, 16'hA00A);
    chk("model_pin_a", e_cmd[1], 16'hA00A);
    fetch(16'h0004, 16'hE00E, "fetch4_big");
    chk("fetch4_small_oor", cmd_b, DFLT);
    fetch(16'h0003, 16'hD00D, "fetch3_big");
    chk("fetch3_small", cmd_b, 16'hD00D);
    @(negedge clk); load_en = 1;
    @(negedge clk); chk("ovf_cleared", ovf_b, 1'b0); chk("load_busy", busy_b, 1'b1);
    load_en = 0;
    @(negedge clk); chk("done_small", done_b, 1'b1);

    // 6: reset in the middle of a load
    @(negedge clk); load_en = 1;
    @(negedge clk); load_valid = 1; load_data = 16'h1111;
    @(negedge clk); load_data = 16'h2222;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; load_en = 0; load_valid = 0;
    wait_clear("midload_rst");
    fetch(16'h0000, DFLT, "fetch0_after_rst");

    // 7: randomized traffic against the model
    tb_in_load = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = (($urandom % 700) == 0);
      if (tb_in_load) begin
        fetch_req = $urandom % 2;
        if (($urandom % 12) == 0) begin
          load_en = 0; tb_in_load = 0;
        end
        load_valid = $urandom % 2;
        load_data  = 16'($urandom);
      end else begin
        load_valid = $urandom % 2;
        if (($urandom % 40) == 0) begin
          load_en = 1; tb_in_load = 1;
        end
        fetch_req   = (($urandom % 4) != 0);
        fetch_stall = (($urandom % 5) == 0);
        r = $urandom % 4;
        case (r)
          0:       fetch_addr = 16'($urandom % 8);
          1:       fetch_addr = 16'($urandom % 256);
          2:       fetch_addr = 16'($urandom % 300);
          default: fetch_addr = 16'($urandom);
        endcase
      end
    end
    @(negedge clk);
    rst = 0; load_en = 0; load_valid = 0; fetch_req = 0; fetch_stall = 0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
